// File: rtl/core_pkg.sv
// Shared core definitions: data width, writeback result-select encodings,
// load funct3 codes and the MEM/WB pipeline register layout.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            regwrite;
    logic [4:0]      rd;
    logic [1:0]      resultsrc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc_plus4;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB capture bus, hazard controls and register-file write port of the
// writeback stage.
interface wb_stage_if;
  import core_pkg::*;

  logic            m_valid;
  logic            m_regwrite;
  logic [4:0]      m_rd;
  logic [1:0]      m_resultsrc;
  logic [2:0]      m_funct3;
  logic [XLEN-1:0] m_alu_result;
  logic [XLEN-1:0] m_rdata;
  logic [XLEN-1:0] m_pc_plus4;
  logic            stall;
  logic            flush;
  logic            we3;
  logic [4:0]      wa3;
  logic [XLEN-1:0] wd3;
  logic            wb_valid;
  logic            load_fault;

  modport master (
    output m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3, m_alu_result, m_rdata,
           m_pc_plus4, stall, flush,
    input  we3, wa3, wd3, wb_valid, load_fault
  );

  modport slave (
    input  m_valid, m_regwrite, m_rd, m_resultsrc, m_funct3, m_alu_result, m_rdata,
           m_pc_plus4, stall, flush,
    output we3, wa3, wd3, wb_valid, load_fault
  );

endinterface

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword/word from a word-aligned
// memory read and flags misaligned or illegal load encodings.
import core_pkg::*;

module load_align #(
  parameter bit TRAP_ON_MISALIGN = 1'b1
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [2:0]      f3_eff;
  logic [1:0]      off;
  logic [XLEN-1:0] shifted;

  always_comb begin
    f3_eff   = funct3;
    off      = offset;
    misalign = 1'b0;
    // Offset bits below the access size are dropped; a trapping build
    // suppresses the write anyway, so the data path is the same in both modes.
    case (funct3)
      F3_LB, F3_LBU: off = offset;
      F3_LH, F3_LHU: begin
        off      = {offset[1], 1'b0};
        misalign = offset[0];
      end
      F3_LW: begin
        off      = 2'b00;
        misalign = (offset != 2'b00);
      end
      default: begin
        f3_eff   = F3_LW;
        off      = 2'b00;
        misalign = 1'b1;
      end
    endcase
    if (!TRAP_ON_MISALIGN) misalign = 1'b0;

    shifted = rdata >> {off, 3'b000};
    case (f3_eff)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  data = {24'h0, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, load fault suppression
// and retired-instruction counter driving the register-file write port.
import core_pkg::*;

module wb_stage #(
  parameter int unsigned INSTRET_W        = 64,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_stage_if.slave            bus,
  output logic [INSTRET_W-1:0] instret
);

  logic                 valid_q;
  wb_entry_t            entry_q;
  logic [INSTRET_W-1:0] instret_q;
  logic [XLEN-1:0]      load_data;
  logic [XLEN-1:0]      wd_sel;
  logic                 misalign;
  logic                 fault;
  logic                 commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (!bus.stall) begin
      valid_q <= bus.m_valid & ~bus.flush;
      entry_q <= '{regwrite:   bus.m_regwrite,
                   rd:         bus.m_rd,
                   resultsrc:  bus.m_resultsrc,
                   funct3:     bus.m_funct3,
                   alu_result: bus.m_alu_result,
                   rdata:      bus.m_rdata,
                   pc_plus4:   bus.m_pc_plus4};
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end
  end

  load_align #(
    .TRAP_ON_MISALIGN(TRAP_ON_MISALIGN)
  ) u_load_align (
    .rdata   (entry_q.rdata),
    .offset  (entry_q.alu_result[1:0]),
    .funct3  (entry_q.funct3),
    .data    (load_data),
    .misalign(misalign)
  );

  // A stalled entry only commits once the stall lifts.
  assign commit = valid_q & ~bus.stall;
  assign fault  = misalign & (entry_q.resultsrc == RESULTSRC_LOAD);

  always_comb begin
    case (entry_q.resultsrc)
      RESULTSRC_LOAD: wd_sel = load_data;
      RESULTSRC_PC4:  wd_sel = entry_q.pc_plus4;
      default:        wd_sel = entry_q.alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (commit && !fault) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign bus.we3        = commit & entry_q.regwrite & (entry_q.rd != 5'd0) & ~fault;
  assign bus.wa3        = valid_q ? entry_q.rd : 5'd0;
  assign bus.wd3        = valid_q ? wd_sel : '0;
  assign bus.wb_valid   = valid_q;
  assign bus.load_fault = commit & fault;
  assign instret        = instret_q;

endmodule
